// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache, one 32-bit instruction per line.
// On a hit it answers fetch one cycle later. On a miss it raises a refill
// request that is held until memory echoes the matching PC.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STAT_EN.
module icache_ctrl #(
    parameter int INDEX_WIDTH = 5,
    parameter int TAG_WIDTH   = 26,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if2cache_en,
    input  logic [ADDR_WIDTH-1:0] if2cache_PC,
    input  logic                  clear_in,
    output logic                  cache2if_valid,
    output logic [31:0]           cache2if_inst,
    output logic [ADDR_WIDTH-1:0] cache2if_PC,
    output logic                  cache_busy,
    output logic                  cache2mem_upd_en,
    output logic [ADDR_WIDTH-1:0] cache2mem_PC,
    input  logic                  mem_rdy,
    input  logic [31:0]           mem2cache_inst,
    input  logic [ADDR_WIDTH-1:0] mem2cache_PC
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    localparam int LINES = 1 << INDEX_WIDTH;

    // DRAIN: fetch was flushed but the refill already started and must finish.
    typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [31:0]             resp_inst_q, resp_inst_d;
    logic [ADDR_WIDTH-1:0]   resp_pc_q, resp_pc_d;
    logic                    upd_en_q, upd_en_d;
    logic [ADDR_WIDTH-1:0]   mem_pc_q, mem_pc_d;

    // Tag and data arrays carry no reset; valid_q alone decides whether a line is usable.
    logic [TAG_WIDTH-1:0]    tag_arr  [LINES];
    logic [31:0]             data_arr [LINES];

    logic [INDEX_WIDTH-1:0]  req_idx, fill_idx;
    logic [TAG_WIDTH-1:0]    req_tag, fill_tag;
    logic                    req_hit, fill_match, line_we;

    // The PC is split into a halfword-granular index and the tag above it; bit 0 is ignored.
    assign req_idx    = if2cache_PC[INDEX_WIDTH:1];
    assign req_tag    = if2cache_PC[ADDR_WIDTH-1:INDEX_WIDTH+1];
    assign fill_idx   = mem_pc_q[INDEX_WIDTH:1];
    assign fill_tag   = mem_pc_q[ADDR_WIDTH-1:INDEX_WIDTH+1];
    assign req_hit    = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
    assign fill_match = mem_rdy && (mem2cache_PC == mem_pc_q);

    assign cache2if_valid   = resp_valid_q;
    assign cache2if_inst    = resp_inst_q;
    assign cache2if_PC      = resp_pc_q;
    assign cache_busy       = (state_q != IDLE);
    assign cache2mem_upd_en = upd_en_q;
    assign cache2mem_PC     = mem_pc_q;

    // Next-state and output decode for the lookup/refill FSM.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        resp_valid_d = 1'b0;
        resp_inst_d  = resp_inst_q;
        resp_pc_d    = resp_pc_q;
        upd_en_d     = upd_en_q;
        mem_pc_d     = mem_pc_q;
        line_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (if2cache_en && !clear_in) begin
                    if (req_hit) begin
                        resp_valid_d = 1'b1;
                        resp_inst_d  = data_arr[req_idx];
                        resp_pc_d    = if2cache_PC;
                    end else begin
                        upd_en_d = 1'b1;
                        mem_pc_d = if2cache_PC;
                        state_d  = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                if (fill_match) begin
                    line_we  = 1'b1;
                    upd_en_d = 1'b0;
                    state_d  = IDLE;
                    if (!clear_in) begin
                        resp_valid_d = 1'b1;
                        resp_inst_d  = mem2cache_inst;
                        resp_pc_d    = mem_pc_q;
                    end
                end else if (clear_in) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fill_match) begin
                    line_we  = 1'b1;
                    upd_en_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (line_we) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    // Control and response registers; rdy_in low freezes everything.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= '0;
            resp_pc_q    <= '0;
            upd_en_q     <= 1'b0;
            mem_pc_q     <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            resp_valid_q <= resp_valid_d;
            resp_inst_q  <= resp_inst_d;
            resp_pc_q    <= resp_pc_d;
            upd_en_q     <= upd_en_d;
            mem_pc_q     <= mem_pc_d;
        end
    end

    // Line fill: tag and data captured from the refill of the latched PC.
    always_ff @(posedge clk) begin
        if (rdy_in && line_we) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= mem2cache_inst;
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic        hit_ev, miss_ev;

    assign hit_ev   = (state_q == IDLE) && if2cache_en && !clear_in && req_hit;
    assign miss_ev  = (state_q == IDLE) && if2cache_en && !clear_in && !req_hit;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // Saturating event counters.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_ev && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (miss_ev && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    // Counter registers, frozen while rdy_in is low.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy_in) begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed vector table, hand-written corner sequences and a
// randomized transaction phase against a line-level cache model.
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic        if2cache_en = 1'b0;
    logic [31:0] if2cache_PC = '0;
    logic        clear_in = 1'b0;
    logic        mem_rdy = 1'b0;
    logic [31:0] mem2cache_inst = '0;
    logic [31:0] mem2cache_PC = '0;
    logic        cache2if_valid;
    logic [31:0] cache2if_inst;
    logic [31:0] cache2if_PC;
    logic        cache_busy;
    logic        cache2mem_upd_en;
    logic [31:0] cache2mem_PC;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_ctrl #(.INDEX_WIDTH(5), .TAG_WIDTH(26), .ADDR_WIDTH(32)) dut (
        .clk              (clk),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .if2cache_en      (if2cache_en),
        .if2cache_PC      (if2cache_PC),
        .clear_in         (clear_in),
        .cache2if_valid   (cache2if_valid),
        .cache2if_inst    (cache2if_inst),
        .cache2if_PC      (cache2if_PC),
        .cache_busy       (cache_busy),
        .cache2mem_upd_en (cache2mem_upd_en),
        .cache2mem_PC     (cache2mem_PC),
        .mem_rdy          (mem_rdy),
        .mem2cache_inst   (mem2cache_inst),
        .mem2cache_PC     (mem2cache_PC)
`ifdef ICACHE_STAT_EN
        ,
        .hit_cnt          (hit_cnt),
        .miss_cnt         (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rdy, en, clr, mrdy;
        logic [31:0] pc, minst, mpc;
        logic        ev, eu, eb;
        logic [31:0] einst, epc, empc;
    } vec_t;

    vec_t vt [24];

    function automatic vec_t mkv(input logic rdy, input logic en, input logic clr,
                                 input logic [31:0] pc, input logic mrdy,
                                 input logic [31:0] minst, input logic [31:0] mpc,
                                 input logic ev, input logic eu, input logic eb,
                                 input logic [31:0] einst, input logic [31:0] epc,
                                 input logic [31:0] empc);
        vec_t v;
        v.rdy = rdy; v.en = en; v.clr = clr; v.pc = pc; v.mrdy = mrdy;
        v.minst = minst; v.mpc = mpc; v.ev = ev; v.eu = eu; v.eb = eb;
        v.einst = einst; v.epc = epc; v.empc = empc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic en, input logic clr, input logic [31:0] pc,
                         input logic mrdy, input logic [31:0] minst, input logic [31:0] mpc);
        rdy_in = rdy; if2cache_en = en; clear_in = clr; if2cache_PC = pc;
        mem_rdy = mrdy; mem2cache_inst = minst; mem2cache_PC = mpc;
    endtask

    task automatic idle_in();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic expect_out(input string tag, input logic ev, input logic eu, input logic eb,
                              input logic [31:0] einst, input logic [31:0] epc,
                              input logic [31:0] empc);
        chk($sformatf("%s.valid", tag), {31'b0, cache2if_valid}, {31'b0, ev});
        chk($sformatf("%s.upd_en", tag), {31'b0, cache2mem_upd_en}, {31'b0, eu});
        chk($sformatf("%s.busy", tag), {31'b0, cache_busy}, {31'b0, eb});
        if (ev) begin
            chk($sformatf("%s.inst", tag), cache2if_inst, einst);
            chk($sformatf("%s.pc", tag), cache2if_PC, epc);
        end
        if (eu) begin
            chk($sformatf("%s.mem_pc", tag), cache2mem_PC, empc);
        end
    endtask

    // Line-level reference model: one entry per index, keyed by tag.
    bit          m_val [32];
    logic [25:0] m_tag [32];
    logic [31:0] m_dat [32];
    int          n_hit = 0;
    int          n_miss = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic rand_txn(input int t);
        logic [31:0] pc, junk;
        int          idx, k;
        logic [25:0] tg;
        logic        clr_req, cancelled, clr_last;
        pc = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 1)
             | 32'($urandom_range(0, 1));
        idx = int'((pc >> 1) % 32);
        tg = 26'(pc >> 6);
        clr_req = ($urandom_range(0, 7) == 0);
        drive(1'b1, 1'b1, clr_req, pc, 1'b0, 32'h0, 32'h0);
        step();
        idle_in();
        if (clr_req) begin
            expect_out($sformatf("rnd%0d.dropped", t), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        end else if (m_val[idx] && m_tag[idx] == tg) begin
            n_hit++;
            expect_out($sformatf("rnd%0d.hit", t), 1'b1, 1'b0, 1'b0, m_dat[idx], pc, 32'h0);
        end else begin
            n_miss++;
            expect_out($sformatf("rnd%0d.miss", t), 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, pc);
            cancelled = 1'b0;
            k = $urandom_range(0, 4);
            for (int j = 0; j < k; j++) begin
                junk = $urandom;
                case ($urandom_range(0, 3))
                    0: drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, junk, 1'b0, 32'h0, 32'h0);
                    1: drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, junk, pc ^ 32'h40);
                    2: begin
                        drive(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
                        cancelled = 1'b1;
                    end
                    default: drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, junk, pc);
                endcase
                step();
                idle_in();
                expect_out($sformatf("rnd%0d.wait%0d", t, j), 1'b0, 1'b1, 1'b1,
                           32'h0, 32'h0, pc);
            end
            clr_last = ($urandom_range(0, 3) == 0);
            drive(1'b1, 1'b0, clr_last, 32'h0, 1'b1, mem_word(pc), pc);
            step();
            idle_in();
            cancelled = cancelled | clr_last;
            expect_out($sformatf("rnd%0d.fill", t), !cancelled, 1'b0, 1'b0,
                       mem_word(pc), pc, 32'h0);
            m_val[idx] = 1'b1;
            m_tag[idx] = tg;
            m_dat[idx] = mem_word(pc);
        end
    endtask

    initial begin
        vt[0]  = mkv(1,1,0,32'h10,0,0,0,                    0,1,1,0,0,32'h10);
        vt[1]  = mkv(1,0,0,0,0,0,0,                         0,1,1,0,0,32'h10);
        vt[2]  = mkv(1,0,0,0,1,32'h00A00093,32'h10,         1,0,0,32'h00A00093,32'h10,0);
        vt[3]  = mkv(1,1,0,32'h10,0,0,0,                    1,0,0,32'h00A00093,32'h10,0);
        vt[4]  = mkv(1,1,0,32'h50,0,0,0,                    0,1,1,0,0,32'h50);
        vt[5]  = mkv(1,0,0,0,1,32'h00100113,32'h50,         1,0,0,32'h00100113,32'h50,0);
        vt[6]  = mkv(1,1,0,32'h10,0,0,0,                    0,1,1,0,0,32'h10);
        vt[7]  = mkv(1,0,0,0,1,32'h00A00093,32'h10,         1,0,0,32'h00A00093,32'h10,0);
        vt[8]  = mkv(1,1,0,32'h20,0,0,0,                    0,1,1,0,0,32'h20);
        vt[9]  = mkv(1,0,1,0,0,0,0,                         0,1,1,0,0,32'h20);
        vt[10] = mkv(1,0,0,0,1,32'h12345678,32'h20,         0,0,0,0,0,0);
        vt[11] = mkv(1,1,0,32'h20,0,0,0,                    1,0,0,32'h12345678,32'h20,0);
        vt[12] = mkv(1,1,0,32'h28,0,0,0,                    0,1,1,0,0,32'h28);
        vt[13] = mkv(1,0,0,0,1,32'hDEADDEAD,32'h2C,         0,1,1,0,0,32'h28);
        vt[14] = mkv(0,0,0,0,1,32'hCAFEBABE,32'h28,         0,1,1,0,0,32'h28);
        vt[15] = mkv(0,1,1,32'h10,1,32'hCAFEBABE,32'h28,    0,1,1,0,0,32'h28);
        vt[16] = mkv(0,0,0,0,1,32'hCAFEBABE,32'h28,         0,1,1,0,0,32'h28);
        vt[17] = mkv(1,1,0,32'h10,0,0,0,                    0,1,1,0,0,32'h28);
        vt[18] = mkv(1,0,0,0,1,32'hCAFEBABE,32'h28,         1,0,0,32'hCAFEBABE,32'h28,0);
        vt[19] = mkv(1,1,1,32'h30,0,0,0,                    0,0,0,0,0,0);
        vt[20] = mkv(1,0,0,0,0,0,0,                         0,0,0,0,0,0);
        vt[21] = mkv(1,1,0,32'h34,0,0,0,                    0,1,1,0,0,32'h34);
        vt[22] = mkv(1,0,1,0,1,32'h11112222,32'h34,         0,0,0,0,0,0);
        vt[23] = mkv(1,1,0,32'h34,0,0,0,                    1,0,0,32'h11112222,32'h34,0);

        // Reset state
        drive(1'b1, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 32'h0);
        step();
        step();
        expect_out("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("reset.inst", cache2if_inst, 32'h0);
        chk("reset.pc", cache2if_PC, 32'h0);
        chk("reset.mem_pc", cache2mem_PC, 32'h0);
        idle_in();
        rst_in = 1'b1;
        step();

        // Directed vector table
        for (int i = 0; i < 24; i++) begin
            drive(vt[i].rdy, vt[i].en, vt[i].clr, vt[i].pc, vt[i].mrdy, vt[i].minst, vt[i].mpc);
            step();
            expect_out($sformatf("vec%0d", i), vt[i].ev, vt[i].eu, vt[i].eb,
                       vt[i].einst, vt[i].epc, vt[i].empc);
`ifdef ICACHE_STAT_EN
            if (i == 3) begin
                chk("stat.hit_after_hit", hit_cnt, 32'd1);
                chk("stat.miss_after_hit", miss_cnt, 32'd1);
            end
`endif
        end
        idle_in();

        // Valid pulse holds while rdy_in is low, then falls
        drive(1'b1, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 32'h0);
        step();
        expect_out("hold.hit", 1'b1, 1'b0, 1'b0, 32'h00A00093, 32'h10, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        expect_out("hold.frozen", 1'b1, 1'b0, 1'b0, 32'h00A00093, 32'h10, 32'h0);
        idle_in();
        step();
        expect_out("hold.released", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        // Asynchronous reset in the middle of a refill clears valid bits
        drive(1'b1, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 32'h0);
        step();
        idle_in();
        expect_out("rstmid.miss", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h40);
        #2;
        rst_in = 1'b0;
        #1;
        expect_out("rstmid.async", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("rstmid.mem_pc", cache2mem_PC, 32'h0);
        step();
        rst_in = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 32'h0);
        step();
        idle_in();
        expect_out("rstmid.cold", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h10);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00A00093, 32'h10);
        step();
        idle_in();
        expect_out("rstmid.fill", 1'b1, 1'b0, 1'b0, 32'h00A00093, 32'h10, 32'h0);

        // Randomized transactions from a clean reset
        rst_in = 1'b0;
        step();
        rst_in = 1'b1;
        step();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = 1'b0;
        end
        for (int t = 0; t < 300; t++) begin
            rand_txn(t);
        end
`ifdef ICACHE_STAT_EN
        chk("stat.rand_hits", hit_cnt, 32'(n_hit));
        chk("stat.rand_misses", miss_cnt, 32'(n_miss));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped instruction cache between instruction fetch and the memory controller.
- Serves fetch requests from stored lines on a hit.
- On a miss it raises a single refill request toward the memory controller, holds it until the byte-serial instruction read completes, then writes the returned instruction into the line and forwards it to fetch.
- Each line holds one 32-bit instruction.

Parameters:
INDEX_WIDTH, 5, line index bits; line count = 2^INDEX_WIDTH
TAG_WIDTH, 26, tag bits; must equal 32 - INDEX_WIDTH - 1
ADDR_WIDTH, 32, PC width

Ports:
clk  in  1  clock, rising edge
rst_in  in  1  asynchronous reset, active-low
rdy_in  in  1  global enable; low freezes all state
if2cache_en  in  1  fetch request strobe, one cycle
if2cache_PC  in  ADDR_WIDTH  fetch address
clear_in  in  1  flush from commit/branch recovery; cancels outstanding fetch
cache2if_valid  out  1  one-cycle pulse, instruction returned
cache2if_inst  out  32  returned instruction
cache2if_PC  out  ADDR_WIDTH  PC of returned instruction
cache_busy  out  1  high whenever state != IDLE
cache2mem_upd_en  out  1  refill request level
cache2mem_PC  out  ADDR_WIDTH  refill address
mem_rdy  in  1  refill complete pulse
mem2cache_inst  in  32  refill instruction, valid with mem_rdy
mem2cache_PC  in  ADDR_WIDTH  refill address echo, valid with mem_rdy

Behaviour:
- Address split:
  - index = PC[INDEX_WIDTH:1], halfword granular.
  - tag = PC[31:INDEX_WIDTH+1].
  - PC[0] ignored.
- Storage: valid[2^INDEX_WIDTH], tag array, data array.
- Reset, while rst_in low, asynchronously:
  - All valid bits 0.
  - State IDLE.
  - cache2if_valid 0, cache2if_inst 0, cache2if_PC 0.
  - cache2mem_upd_en 0, cache2mem_PC 0.
  - Data and tag arrays are not cleared.
- rdy_in low: no register changes. Outputs hold.
- States:
  - IDLE:
    - if2cache_en with no clear_in and a hit (valid and tag match): next cycle cache2if_valid=1, inst from line, PC echoed; stay IDLE. Hit latency 1 cycle.
    - if2cache_en with no clear_in and a miss: latch PC; next cycle cache2mem_upd_en=1, cache2mem_PC=PC; go WAIT_MEM.
  - WAIT_MEM:
    - cache2mem_upd_en and cache2mem_PC held stable until mem_rdy.
    - On mem_rdy with mem2cache_PC equal to the latched PC: write line (valid=1, tag, data); upd_en drops next cycle; cache2if_valid pulses next cycle with mem2cache_inst; go IDLE.
    - mem_rdy with a mismatched PC: ignore, keep waiting.
  - DRAIN:
    - Entered from WAIT_MEM when clear_in=1.
    - upd_en stays high; the memory controller cannot abort a started transfer.
    - On matching mem_rdy: line is still written, since the data is correct; no cache2if_valid pulse; go IDLE.
- Simultaneous events:
  - clear_in together with if2cache_en in IDLE: request dropped, no response.
  - clear_in together with mem_rdy in WAIT_MEM: line written, response suppressed, go IDLE directly.
  - clear_in in DRAIN or IDLE: no further effect.
  - if2cache_en while cache_busy: ignored. Fetch must wait until cache_busy is low.
- Aliasing: two PCs with equal index evict each other; the last refill wins.
- Reset mid-refill: state is lost. The memory controller is reset by the same event.

Optional Feature:
ICACHE_STAT_EN:
- When defined, adds outputs hit_cnt[31:0] and miss_cnt[31:0].
- Both counters reset to 0.
- hit_cnt increments on each accepted IDLE hit.
- miss_cnt increments on each IDLE-to-WAIT_MEM transition.
- Counters saturate at 32'hFFFFFFFF and do not count while rdy_in is low.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss: rst_in low then high, request PC=0x00000010 → next cycle upd_en=1, cache2mem_PC=0x10. Then mem_rdy, inst=0x00A00093, PC=0x10 → next cycle cache2if_valid=1, inst 0x00A00093, PC 0x10; cache_busy=0.
- Hit: after the cold miss, request PC=0x10 → next cycle valid=1, inst 0x00A00093, upd_en stays 0.
- Conflict eviction:
  - Fill PC=0x10.
  - Request PC=0x50 (same index 8, different tag) → miss, refill with 0x00100113.
  - Request 0x10 again → miss.
- Flush mid-refill: miss on PC=0x20, pulse clear_in during WAIT_MEM, then mem_rdy with PC=0x20, inst 0x12345678 → no cache2if_valid. A later request to 0x20 hits with 0x12345678.
- Stale echo and stall:
  - mem_rdy with PC=0x24 while waiting for 0x20 → ignored, upd_en still 1.
  - rdy_in low for 3 cycles during WAIT_MEM → outputs unchanged.
  - Completion proceeds after rdy_in returns high.
- Busy/simultaneous: if2cache_en during WAIT_MEM → ignored. clear_in together with if2cache_en (PC=0x30) in IDLE → no response, no upd_en.
  - With ICACHE_STAT_EN defined: after the cold miss and hit scenarios, hit_cnt=1, miss_cnt=1.
